stg_ma: RTL and testbench

- Memory-access stage directly downstream of stg_ex. Registers its outputs toward writeback.
- Loads and stores run over a valid/ready data-memory port with variable latency; other ops pass through with 1-cycle latency.
- Stalls the front of the pipe while a memory transaction is outstanding.
- Honours flush, including a flush that arrives while a read is in flight.

---
 rtl/stg_ma.sv | 236 +++++++++++++++++++++++
 tb/tb_stg_ma.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stg_ma.sv
// ============================================================================
//  Module   : stg_ma
//  Purpose  : Memory-access pipeline stage. Non-memory ops pass through in one
//             cycle. Loads and stores use a valid/ready data-memory port and
//             stall upstream until they complete. Handles flush in every state.
//  Option   : AMBER_MA_TIMEOUT_EN adds a MAX_WAIT response timeout and ow_fault.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef HBIT_OPC
`define HBIT_OPC 7
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef OPC_NOP
`define OPC_NOP 8'h00
`define OPC_ADD 8'h01
`define OPC_LDW 8'h10
`define OPC_LDB 8'h11
`define OPC_STW 8'h18
`define OPC_STB 8'h19
`endif

module stg_ma #(
    parameter int MAX_WAIT = 64
) (
    input  logic                    iw_clk,
    input  logic                    iw_rst,
    input  logic [47:0]             iw_pc,
    input  logic [`HBIT_OPC:0]      iw_opc,
    input  logic [47:0]             iw_addr,
    input  logic [23:0]             iw_result,
    input  logic [`HBIT_TGT_GP:0]   iw_tgt_gp,
    input  logic                    iw_tgt_gp_we,
    input  logic                    iw_flush,
    output logic                    ow_stall,
    output logic                    ow_dm_valid,
    input  logic                    iw_dm_ready,
    output logic                    ow_dm_we,
    output logic [47:0]             ow_dm_addr,
    output logic [23:0]             ow_dm_wdata,
    input  logic                    iw_dm_rvalid,
    input  logic [23:0]             iw_dm_rdata,
`ifdef AMBER_MA_TIMEOUT_EN
    output logic                    ow_fault,
`endif
    output logic [47:0]             ow_pc,
    output logic [`HBIT_OPC:0]      ow_opc,
    output logic [23:0]             ow_result,
    output logic [`HBIT_TGT_GP:0]   ow_tgt_gp,
    output logic                    ow_tgt_gp_we
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_REQ   = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_DRAIN = 2'd3;

    // The wait counter is 7 bits wide, so the limit must fit in it.
    if (MAX_WAIT < 2 || MAX_WAIT > 127) begin : g_max_wait_chk
        $error("stg_ma: MAX_WAIT must be in 2..127");
    end

    logic [1:0]              r_state;
    logic [1:0]              w_state_nx;
    logic [47:0]             r_pc_l;
    logic [`HBIT_OPC:0]      r_opc_l;
    logic [47:0]             r_addr_l;
    logic [23:0]             r_data_l;
    logic [`HBIT_TGT_GP:0]   r_tgt_l;
    logic                    r_we_l;
    logic                    r_is_st;

    logic [47:0]             r_out_pc,     w_pc_nx;
    logic [`HBIT_OPC:0]      r_out_opc,    w_opc_nx;
    logic [23:0]             r_out_result, w_res_nx;
    logic [`HBIT_TGT_GP:0]   r_out_tgt,    w_tgt_nx;
    logic                    r_out_we,     w_we_nx;
    logic                    w_in_ld, w_in_st, w_accept;

    assign w_in_ld = (iw_opc == `OPC_LDW) || (iw_opc == `OPC_LDB);
    assign w_in_st = (iw_opc == `OPC_STW) || (iw_opc == `OPC_STB);

`ifdef AMBER_MA_TIMEOUT_EN
    localparam logic [6:0] c_WAIT_LAST = 7'(MAX_WAIT - 1);
    logic [6:0] r_wait_cnt;
    logic       r_fault;
    logic       w_fault_nx;
`endif

    // Every cycle emits either a retirement or a bubble toward writeback.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_pc_nx    = '0;
        w_opc_nx   = `OPC_NOP;
        w_res_nx   = '0;
        w_tgt_nx   = '0;
        w_we_nx    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (!iw_flush) begin
                    if (w_in_ld || w_in_st) begin
                        w_accept   = 1'b1;
                        w_state_nx = c_S_REQ;
                    end else begin
                        w_pc_nx  = iw_pc;
                        w_opc_nx = iw_opc;
                        w_res_nx = iw_result;
                        w_tgt_nx = iw_tgt_gp;
                        w_we_nx  = iw_tgt_gp_we;
                    end
                end
            end
            c_S_REQ: begin
                if (iw_dm_ready) begin
                    if (r_is_st) begin
                        w_state_nx = c_S_IDLE;
                        if (!iw_flush) begin
                            // Stores retire with the store data as result, no GP write.
                            w_pc_nx  = r_pc_l;
                            w_opc_nx = r_opc_l;
                            w_res_nx = r_data_l;
                            w_tgt_nx = r_tgt_l;
                        end
                    end else if (iw_dm_rvalid) begin
                        w_state_nx = c_S_IDLE;
                        if (!iw_flush) begin
                            w_pc_nx  = r_pc_l;
                            w_opc_nx = r_opc_l;
                            w_res_nx = iw_dm_rdata;
                            w_tgt_nx = r_tgt_l;
                            w_we_nx  = r_we_l;
                        end
                    end else begin
                        w_state_nx = iw_flush ? c_S_DRAIN : c_S_WAIT;
                    end
                end else if (iw_flush) begin
                    w_state_nx = c_S_IDLE;
                end
            end
            c_S_WAIT: begin
                if (iw_dm_rvalid) begin
                    w_state_nx = c_S_IDLE;
                    if (!iw_flush) begin
                        w_pc_nx  = r_pc_l;
                        w_opc_nx = r_opc_l;
                        w_res_nx = iw_dm_rdata;
                        w_tgt_nx = r_tgt_l;
                        w_we_nx  = r_we_l;
                    end
                end else if (iw_flush) begin
                    w_state_nx = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                if (iw_dm_rvalid) w_state_nx = c_S_IDLE;
            end
            default: w_state_nx = c_S_IDLE;
        endcase
`ifdef AMBER_MA_TIMEOUT_EN
        // Staying put in a busy state means the awaited event has not come.
        w_fault_nx = 1'b0;
        if (r_state != c_S_IDLE && w_state_nx == r_state && r_wait_cnt == c_WAIT_LAST) begin
            w_state_nx = c_S_IDLE;
            w_fault_nx = 1'b1;
        end
`endif
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state      <= c_S_IDLE;
            r_pc_l       <= '0;
            r_opc_l      <= `OPC_NOP;
            r_addr_l     <= '0;
            r_data_l     <= '0;
            r_tgt_l      <= '0;
            r_we_l       <= 1'b0;
            r_is_st      <= 1'b0;
            r_out_pc     <= '0;
            r_out_opc    <= `OPC_NOP;
            r_out_result <= '0;
            r_out_tgt    <= '0;
            r_out_we     <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_out_pc     <= w_pc_nx;
            r_out_opc    <= w_opc_nx;
            r_out_result <= w_res_nx;
            r_out_tgt    <= w_tgt_nx;
            r_out_we     <= w_we_nx;
            if (w_accept) begin
                r_pc_l   <= iw_pc;
                r_opc_l  <= iw_opc;
                r_addr_l <= iw_addr;
                r_data_l <= iw_result;
                r_tgt_l  <= iw_tgt_gp;
                r_we_l   <= iw_tgt_gp_we;
                r_is_st  <= w_in_st;
            end
        end
    end

`ifdef AMBER_MA_TIMEOUT_EN
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_fault <= w_fault_nx;
            if (w_state_nx != r_state)
                r_wait_cnt <= '0;
            else if (r_state != c_S_IDLE)
                r_wait_cnt <= r_wait_cnt + 7'd1;
        end
    end
    assign ow_fault = r_fault;
`endif

    assign ow_stall     = (r_state != c_S_IDLE) || w_accept;
    assign ow_dm_valid  = (r_state == c_S_REQ);
    assign ow_dm_we     = r_is_st;
    assign ow_dm_addr   = r_addr_l;
    assign ow_dm_wdata  = r_data_l;
    assign ow_pc        = r_out_pc;
    assign ow_opc       = r_out_opc;
    assign ow_result    = r_out_result;
    assign ow_tgt_gp    = r_out_tgt;
    assign ow_tgt_gp_we = r_out_we;

endmodule

`default_nettype wire

// File: tb/tb_stg_ma.sv
// ============================================================================
//  Module   : tb_stg_ma
//  Purpose  : Self-checking bench for stg_ma: vector table for pass-through ops,
//             scoreboard of expected retirements, directed memory sequences.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef HBIT_OPC
`define HBIT_OPC 7
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef OPC_NOP
`define OPC_NOP 8'h00
`define OPC_ADD 8'h01
`define OPC_LDW 8'h10
`define OPC_LDB 8'h11
`define OPC_STW 8'h18
`define OPC_STB 8'h19
`endif

module tb_stg_ma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] pc = '0;
    logic [7:0]  opc = `OPC_NOP;
    logic [47:0] addr = '0;
    logic [23:0] result = '0;
    logic [3:0]  tgt = '0;
    logic        tgt_we = 1'b0;
    logic        flush = 1'b0;
    logic        dm_ready = 1'b0;
    logic        dm_rvalid = 1'b0;
    logic [23:0] dm_rdata = '0;
    logic        ow_stall, ow_dm_valid, ow_dm_we, ow_tgt_gp_we;
    logic [47:0] ow_dm_addr, ow_pc;
    logic [23:0] ow_dm_wdata, ow_result;
    logic [7:0]  ow_opc;
    logic [3:0]  ow_tgt_gp;
`ifdef AMBER_MA_TIMEOUT_EN
    logic        ow_fault;
`endif

    stg_ma #(.MAX_WAIT(8)) dut (
        .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_opc(opc), .iw_addr(addr),
        .iw_result(result), .iw_tgt_gp(tgt), .iw_tgt_gp_we(tgt_we), .iw_flush(flush),
        .ow_stall(ow_stall), .ow_dm_valid(ow_dm_valid), .iw_dm_ready(dm_ready),
        .ow_dm_we(ow_dm_we), .ow_dm_addr(ow_dm_addr), .ow_dm_wdata(ow_dm_wdata),
        .iw_dm_rvalid(dm_rvalid), .iw_dm_rdata(dm_rdata),
`ifdef AMBER_MA_TIMEOUT_EN
        .ow_fault(ow_fault),
`endif
        .ow_pc(ow_pc), .ow_opc(ow_opc), .ow_result(ow_result),
        .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] pc;
        logic [7:0]  opc;
        logic [23:0] res;
        logic [3:0]  tgt;
        logic        we;
    } ret_t;

    typedef struct {
        logic [7:0]  opc;
        logic [47:0] pc;
        logic [23:0] res;
        logic [3:0]  tgt;
        logic        we;
        logic        fl;
    } vec_t;

    ret_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   hs    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        pc = '0; opc = `OPC_NOP; addr = '0; result = '0; tgt = '0; tgt_we = 1'b0; flush = 1'b0;
    endtask

    task automatic set_mem(input logic [7:0] o, input logic [47:0] p, input logic [47:0] a,
                           input logic [23:0] d, input logic [3:0] t);
        opc = o; pc = p; addr = a; result = d; tgt = t; tgt_we = 1'b1; flush = 1'b0;
    endtask

    // Any non-bubble output must match the oldest expected retirement.
    always @(negedge clk) begin
        if (!rst && ow_opc != `OPC_NOP) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_retire: got opc=%0h pc=%0h res=%0h want none", ow_opc, ow_pc, ow_result);
            end else begin
                chk("retire", {ow_pc, ow_opc, ow_result, ow_tgt_gp, ow_tgt_gp_we}, exp_q.pop_front());
            end
        end
        if (!rst && ow_dm_valid && dm_ready) hs++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   hs0;
        int   n;

        vt[0] = '{`OPC_ADD, 48'h100, 24'h00_1234, 4'd3, 1'b1, 1'b0};
        vt[1] = '{`OPC_ADD, 48'h104, 24'hFFFFFF, 4'd15, 1'b1, 1'b0};
        vt[2] = '{8'h22,    48'h108, 24'h000000, 4'd0, 1'b0, 1'b0};
        vt[3] = '{`OPC_ADD, 48'h10C, 24'h0BADF0, 4'd7, 1'b1, 1'b1};
        vt[4] = '{8'h7F,    48'hFFFF_FFFF_FFFF, 24'h800001, 4'd8, 1'b1, 1'b0};
        vt[5] = '{8'h01,    48'h110, 24'h5A5A5A, 4'd1, 1'b0, 1'b0};

        // Reset state
        set_nop();
        tick(); tick(); tick();
        chk("rst_opc", ow_opc, `OPC_NOP);
        chk("rst_outs", {ow_pc, ow_result, ow_tgt_gp, ow_tgt_gp_we}, 0);
        chk("rst_valid_stall", {ow_dm_valid, ow_stall}, 0);
        rst = 1'b0;

        // Pass-through table
        for (int i = 0; i < 6; i++) begin
            opc = vt[i].opc; pc = vt[i].pc; result = vt[i].res;
            tgt = vt[i].tgt; tgt_we = vt[i].we; flush = vt[i].fl;
            if (!vt[i].fl) exp_q.push_back('{vt[i].pc, vt[i].opc, vt[i].res, vt[i].tgt, vt[i].we});
            #1;
            chk("pass_stall", ow_stall, 1'b0);
            tick();
        end
        set_nop();
        tick();

        // Load: ready on first REQ cycle, rvalid two cycles later
        hs0 = hs;
        set_mem(`OPC_LDW, 48'h200, 48'h400, 24'h0, 4'd5);
        #1; chk("ld_accept_stall", ow_stall, 1'b1);
        tick();
        set_mem(`OPC_ADD, 48'h999, 48'h0, 24'h111111, 4'd9);
        dm_ready = 1'b1;
        #1;
        chk("ld_req", {ow_stall, ow_dm_valid, ow_dm_we, ow_dm_addr}, {1'b1, 1'b1, 1'b0, 48'h400});
        tick();
        dm_ready = 1'b0;
        chk("ld_wait1", {ow_stall, ow_dm_valid}, 2'b10);
        tick();
        chk("ld_wait2", ow_stall, 1'b1);
        dm_rvalid = 1'b1; dm_rdata = 24'hABCDEF;
        exp_q.push_back('{48'h200, `OPC_LDW, 24'hABCDEF, 4'd5, 1'b1});
        tick();
        dm_rvalid = 1'b0; set_nop();
        #1; chk("ld_done_stall", ow_stall, 1'b0);
        chk("ld_hs_count", hs - hs0, 1);

        // Store under backpressure
        tick();
        set_mem(`OPC_STW, 48'h300, 48'h800, 24'h55AA55, 4'd2);
        tick();
        set_nop();
        for (int i = 0; i < 4; i++) begin
            chk("st_hold", {ow_dm_valid, ow_dm_we, ow_dm_addr, ow_dm_wdata, ow_stall},
                {1'b1, 1'b1, 48'h800, 24'h55AA55, 1'b1});
            tick();
        end
        dm_ready = 1'b1;
        exp_q.push_back('{48'h300, `OPC_STW, 24'h55AA55, 4'd2, 1'b0});
        tick();
        dm_ready = 1'b0;
        chk("st_done", {ow_dm_valid, ow_stall}, 2'b00);

        // Flush while waiting for load data
        set_mem(`OPC_LDB, 48'h400, 48'h440, 24'h0, 4'd6);
        tick();
        set_nop(); dm_ready = 1'b1;
        tick();
        dm_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_stall", ow_stall, 1'b1);
        tick();
        dm_rvalid = 1'b1; dm_rdata = 24'h123456;
        tick();
        dm_rvalid = 1'b0;
        #1;
        chk("flush_wait_nowrite", {ow_tgt_gp_we, ow_stall}, 2'b00);
        chk("flush_wait_result_is_123456", (ow_result == 24'h123456), 1'b0);
        opc = `OPC_ADD; pc = 48'h500; result = 24'h000777; tgt = 4'd7; tgt_we = 1'b1;
        exp_q.push_back('{48'h500, `OPC_ADD, 24'h000777, 4'd7, 1'b1});
        tick();
        set_nop();

        // Flush in REQ before the handshake
        hs0 = hs;
        set_mem(`OPC_STB, 48'h600, 48'h900, 24'h0000AA, 4'd4);
        tick();
        set_nop(); flush = 1'b1;
        chk("freq_valid", ow_dm_valid, 1'b1);
        tick();
        flush = 1'b0;
        chk("freq_after", {ow_dm_valid, ow_stall}, 2'b00);
        tick();
        chk("freq_no_hs", hs - hs0, 0);

        // Ready and rvalid together in REQ, with a spurious rvalid first in IDLE
        dm_rvalid = 1'b1; dm_rdata = 24'hDEAD00;
        tick();
        dm_rvalid = 1'b0;
        set_mem(`OPC_LDW, 48'h700, 48'h480, 24'h0, 4'd9);
        tick();
        set_nop(); dm_ready = 1'b1; dm_rvalid = 1'b1; dm_rdata = 24'h0F0F0F;
        exp_q.push_back('{48'h700, `OPC_LDW, 24'h0F0F0F, 4'd9, 1'b1});
        tick();
        dm_ready = 1'b0; dm_rvalid = 1'b0;
        chk("simul_done", ow_stall, 1'b0);

        // Store flushed on the handshake cycle: committed but no retirement
        hs0 = hs;
        set_mem(`OPC_STW, 48'h800, 48'hA00, 24'h00BEEF, 4'd3);
        tick();
        set_nop(); dm_ready = 1'b1; flush = 1'b1;
        tick();
        dm_ready = 1'b0; flush = 1'b0;
        chk("st_flush_hs", hs - hs0, 1);
        chk("st_flush_idle", {ow_stall, ow_dm_valid}, 2'b00);

        // Load flushed in IDLE is dropped without a request
        set_mem(`OPC_LDW, 48'h900, 48'hB00, 24'h0, 4'd1);
        flush = 1'b1;
        #1; chk("idle_flush_stall", ow_stall, 1'b0);
        tick();
        set_nop();
        chk("idle_flush_novalid", ow_dm_valid, 1'b0);

`ifdef AMBER_MA_TIMEOUT_EN
        chk("fault_rst_low", ow_fault, 1'b0);
        set_mem(`OPC_LDW, 48'hA00, 48'hC00, 24'h0, 4'd2);
        tick();
        set_nop(); dm_ready = 1'b1;
        tick();
        dm_ready = 1'b0;
        n = 0;
        while (!ow_fault && n < 30) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 8);
        chk("tmo_fault_out", {ow_fault, ow_tgt_gp_we, ow_dm_valid, ow_stall}, 4'b1000);
        tick();
        chk("tmo_fault_pulse", ow_fault, 1'b0);
        tick(); tick();
        dm_rvalid = 1'b1; dm_rdata = 24'h654321;
        tick();
        dm_rvalid = 1'b0;
        chk("tmo_late_rvalid", ow_tgt_gp_we, 1'b0);
`else
        n = 0;
`endif

        tick(); tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
